// File: rtl/sayac_regfile_dump.sv
// sayac_regfile_dump: walks register addresses 0..DEPTH-1 and streams each
// word, tagged with its address, to a consumer.
//
// Handshake: o_out_valid is registered and is raised only from READ. A word
// transfers on a rising edge where o_out_valid & i_out_ready are both high.
// o_out_data/o_out_addr do not change while o_out_valid is high and no
// transfer has happened. i_out_ready never feeds o_out_valid combinationally.
module sayac_regfile_dump #(
    parameter int N     = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_abort,
    output logic [AW-1:0] o_rd_addr,
    input  logic [N-1:0]  i_rd_data,
    output logic [N-1:0]  o_out_data,
    output logic [AW-1:0] o_out_addr,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic [1:0]    o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Last address walked; the counter stops here rather than at 2**AW-1.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state;
    logic [AW-1:0] r_rd_addr;
    logic [N-1:0]  r_out_data;
    logic [AW-1:0] r_out_addr;
    logic          r_out_valid;

    state_t        w_state_nxt;
    logic [AW-1:0] w_rd_addr_nxt;
    logic          w_out_valid_nxt;
    logic          w_capture;
    logic          w_handshake;

    assign w_handshake = r_out_valid & i_out_ready;

    // Next-state and next-register decode; abort overrides everything outside IDLE.
    always_comb begin
        w_state_nxt     = r_state;
        w_rd_addr_nxt   = r_rd_addr;
        w_out_valid_nxt = r_out_valid;
        w_capture       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt   = ST_READ;
                    w_rd_addr_nxt = '0;
                end
            end
            ST_READ: begin
                w_capture       = 1'b1;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = ST_SEND;
            end
            ST_SEND: begin
                if (w_handshake) begin
                    w_out_valid_nxt = 1'b0;
                    if (r_rd_addr == LAST_ADDR) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt   = ST_READ;
                        w_rd_addr_nxt = r_rd_addr + AW'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt   = ST_IDLE;
                w_rd_addr_nxt = '0;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_rd_addr_nxt   = '0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_nxt     = ST_IDLE;
            w_rd_addr_nxt   = '0;
            w_out_valid_nxt = 1'b0;
            w_capture       = 1'b0;
        end
    end

    // State, address counter and valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Output word capture; rd_data is only looked at in READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_addr <= '0;
        end else if (w_capture) begin
            r_out_data <= i_rd_data;
            r_out_addr <= r_rd_addr;
        end
    end

    assign o_rd_addr   = r_rd_addr;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state == ST_READ) || (r_state == ST_SEND);
    assign o_done      = (r_state == ST_DONE);
    assign o_state     = r_state;

endmodule

// File: tb/tb_sayac_regfile_dump.sv
module tb_sayac_regfile_dump;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int N1 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (DEPTH=16) ----------------
  logic          start, abort, out_ready;
  logic [AW-1:0] rd_addr, out_addr;
  logic [N-1:0]  rd_data, out_data;
  logic          out_valid, busy, done;
  logic [1:0]    state;
  logic [N-1:0]  mem [0:D-1];

  assign rd_data = mem[rd_addr];

  sayac_regfile_dump #(.N(N), .AW(AW), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_out_data(out_data), .o_out_addr(out_addr), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_busy(busy), .o_done(done), .o_state(state)
  );

  // ---------------- DUT (DEPTH=1, N=8) ----------------
  logic          start1, abort1, out_ready1;
  logic [AW-1:0] rd_addr1, out_addr1;
  logic [N1-1:0] rd_data1, out_data1;
  logic          out_valid1, busy1, done1;
  logic [1:0]    state1;

  assign rd_data1 = (rd_addr1 == 4'd0) ? 8'h5A : 8'hEE;

  sayac_regfile_dump #(.N(N1), .AW(AW), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_abort(abort1),
    .o_rd_addr(rd_addr1), .i_rd_data(rd_data1),
    .o_out_data(out_data1), .o_out_addr(out_addr1), .o_out_valid(out_valid1),
    .i_out_ready(out_ready1), .o_busy(busy1), .o_done(done1), .o_state(state1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [AW+N-1:0]  exp_q[$];
  logic [AW+N1-1:0] exp1_q[$];
  int hs_cyc[$];
  int done_cnt = 0, done_cyc = 0;
  int done1_cnt = 0, done1_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer is committed at the next rising edge when valid&ready at negedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_extra: got addr=%0d data=%h, expected nothing", out_addr, out_data);
        end else begin
          check("sb_word", 32'({out_addr, out_data}), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (out_valid1 && out_ready1) begin
        if (exp1_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb1_extra: got addr=%0d data=%h, expected nothing", out_addr1, out_data1);
        end else begin
          check("sb1_word", 32'({out_addr1, out_data1}), 32'(exp1_q.pop_front()));
        end
      end
      if (done1) begin done1_cnt++; done1_cyc = cyc; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back({AW'(i), N'(16'hA000 + i)});
  endtask

  task automatic pulse_start(output int sc);
    start = 1'b1;
    tick();
    start = 1'b0;
    sc = cyc;
  endtask

  task automatic wait_word(input int a);
    int n = 0;
    while (!(out_valid && out_addr == AW'(a)) && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL wait_word_%0d: timeout, valid=%0b addr=%0d", a, out_valid, out_addr);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL wait_done: timeout, done=%0b state=%0d", done, state);
    end
  endtask

  // ---------------- stimulus ----------------
  int sc, d0, bad, busy_n;

  initial begin
    start = 0; abort = 0; out_ready = 1;
    start1 = 0; abort1 = 0; out_ready1 = 1;
    for (int i = 0; i < D; i++) mem[i] = N'(16'hA000 + i);

    // reset state
    #2;
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_addr", 32'(out_addr), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // T1: full dump, ready high
    hs_cyc.delete();
    push_words(0, D-1);
    d0 = done_cnt;
    pulse_start(sc);
    busy_n = 0;
    for (int c = 0; c < 2*D; c++) begin
      if (busy) busy_n++;
      tick();
    end
    check("t1_busy_cycles", 32'(busy_n), 32'(2*D));
    check("t1_done_high", 32'(done), 1);
    check("t1_busy_in_done", 32'(busy), 0);
    tick();
    check("t1_done_low", 32'(done), 0);
    check("t1_idle", 32'(state), 0);
    check("t1_done_cnt", 32'(done_cnt - d0), 1);
    check("t1_done_cyc", 32'(done_cyc - sc), 32'(2*D));
    check("t1_hs_count", 32'(hs_cyc.size()), 32'(D));
    bad = 0;
    for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != 2) bad++;
    check("t1_spacing", 32'(bad), 0);
    check("t1_q_empty", 32'(exp_q.size()), 0);

    // T2: backpressure on word 3, rd_data disturbed during the stall
    push_words(0, D-1);
    d0 = done_cnt;
    pulse_start(sc);
    wait_word(3);
    out_ready = 1'b0;
    mem[3] = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      check("t2_stall_valid", 32'(out_valid), 1);
      check("t2_stall_addr", 32'(out_addr), 3);
      check("t2_stall_data", 32'(out_data), 32'h0000A003);
      tick();
    end
    mem[3] = 16'hA003;
    out_ready = 1'b1;
    wait_done();
    tick();
    check("t2_done_cnt", 32'(done_cnt - d0), 1);
    check("t2_done_cyc", 32'(done_cyc - sc), 32'(2*D + 5));
    check("t2_q_empty", 32'(exp_q.size()), 0);

    // T3: start while busy and during DONE are ignored
    hs_cyc.delete();
    push_words(0, D-1);
    d0 = done_cnt;
    pulse_start(sc);
    wait_word(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_idle_after_done", 32'(state), 0);
    check("t3_not_busy", 32'(busy), 0);
    tick(); tick(); tick();
    check("t3_still_idle", 32'(busy), 0);
    check("t3_done_cnt", 32'(done_cnt - d0), 1);
    check("t3_hs_count", 32'(hs_cyc.size()), 32'(D));
    check("t3_q_empty", 32'(exp_q.size()), 0);

    // T4: abort at word 9 in SEND, then restart from 0
    push_words(0, 8);
    d0 = done_cnt;
    pulse_start(sc);
    wait_word(9);
    out_ready = 1'b0;
    tick();
    check("t4_send_hold", 32'(state), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_valid_low", 32'(out_valid), 0);
    check("t4_busy_low", 32'(busy), 0);
    check("t4_done_low", 32'(done), 0);
    check("t4_rd_addr0", 32'(rd_addr), 0);
    out_ready = 1'b1;
    tick(); tick();
    check("t4_no_done", 32'(done_cnt - d0), 0);
    check("t4_q_empty", 32'(exp_q.size()), 0);
    push_words(0, D-1);
    pulse_start(sc);
    wait_done();
    tick();
    check("t4_restart_done", 32'(done_cnt - d0), 1);
    check("t4_restart_q_empty", 32'(exp_q.size()), 0);

    // T5: abort in IDLE beats start
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("t5_abort_idle_state", 32'(state), 0);
    check("t5_abort_idle_busy", 32'(busy), 0);

    // T6: async reset mid-dump during word 5
    push_words(0, 4);
    d0 = done_cnt;
    pulse_start(sc);
    wait_word(5);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_data", 32'(out_data), 0);
    check("t6_rst_addr", 32'(out_addr), 0);
    check("t6_rst_rd_addr", 32'(rd_addr), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_state", 32'(state), 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t6_no_done", 32'(done_cnt - d0), 0);
    check("t6_q_empty", 32'(exp_q.size()), 0);
    push_words(0, D-1);
    pulse_start(sc);
    wait_done();
    tick();
    check("t6_redump_done", 32'(done_cnt - d0), 1);
    check("t6_redump_q_empty", 32'(exp_q.size()), 0);

    // T7: DEPTH=1 instance
    d0 = done1_cnt;
    exp1_q.push_back({4'd0, 8'h5A});
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    sc = cyc;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (rd_addr1 != 4'd0) bad++;
      tick();
    end
    check("t7_rd_addr_stuck0", 32'(bad), 0);
    check("t7_done_cnt", 32'(done1_cnt - d0), 1);
    check("t7_done_cyc", 32'(done1_cyc - sc), 2);
    check("t7_idle", 32'(state1), 0);
    check("t7_q_empty", 32'(exp1_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
